// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Widest request vector the round-robin search understands.
  localparam int RR_MAX = 16;

  // Channel index width; a single channel still needs one bit of index.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // First set bit of req at or after ptr, searching upward and wrapping modulo n.
  // The descending loop lets the closest candidate to ptr overwrite farther ones.
  // Returns ptr when req is empty; callers qualify with |req.
  function automatic int rr_find(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int idx;
    int sel;
    sel = ptr;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[4'(idx)]) sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/edge_evt_chan.sv
// One channel: edge detector, rise/fall pending flags and a sticky overflow flag.
// Latency: an edge sampled at posedge k shows on o_pend_* right after k.
// Backpressure: none; an edge that lands on an already-pending flag merges and sets o_ovf.
module edge_evt_chan (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_grant_clr,
  input  logic i_ovf_clr,
  output logic o_pend_rise,
  output logic o_pend_fall,
  output logic o_ovf
);

  logic r_sig_d;
  logic r_pend_rise;
  logic r_pend_fall;
  logic r_ovf;
  logic w_rise_det;
  logic w_fall_det;
  logic w_ovf_set;

  assign w_rise_det = i_sig & ~r_sig_d & i_rise_en;
  assign w_fall_det = ~i_sig & r_sig_d & i_fall_en;

  // A flag that is being granted away this cycle leaves room for the new edge, so no overflow then.
  assign w_ovf_set = ~i_grant_clr & ((w_rise_det & r_pend_rise) | (w_fall_det & r_pend_fall));

  // Delay line, pending flags (new edge beats grant clear) and sticky overflow (set beats clear).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sig_d     <= 1'b0;
      r_pend_rise <= 1'b0;
      r_pend_fall <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_sig_d     <= i_sig;
      r_pend_rise <= w_rise_det | (r_pend_rise & ~i_grant_clr);
      r_pend_fall <= w_fall_det | (r_pend_fall & ~i_grant_clr);
      r_ovf       <= w_ovf_set | (r_ovf & ~i_ovf_clr);
    end
  end

  assign o_pend_rise = r_pend_rise;
  assign o_pend_fall = r_pend_fall;
  assign o_ovf       = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel edge events and serialises them onto one valid/ready port, round-robin.
// Latency: pending flag at k, grant at k+1, evt_valid high after k+1; at most one event per 2 cycles.
// Backpressure: offer held stable while evt_ready=0; further edges merge into pending flags (ovf on merge).
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_sig,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic              evt_fall,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] ovf_clr
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   w_pend_rise;
  logic [NUM_CH-1:0]   w_pend_fall;
  logic [NUM_CH-1:0]   w_grant;
  logic [RR_MAX-1:0]   w_req;
  logic [CH_W-1:0]     w_sel;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [CH_W-1:0]     r_evt_ch;
  logic                r_evt_rise;
  logic                r_evt_fall;
  logic                w_load;
  logic                w_accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_evt_chan u_chan (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sig       (in_sig[g]),
      .i_rise_en   (rise_en[g]),
      .i_fall_en   (fall_en[g]),
      .i_grant_clr (w_grant[g]),
      .i_ovf_clr   (ovf_clr[g]),
      .o_pend_rise (w_pend_rise[g]),
      .o_pend_fall (w_pend_fall[g]),
      .o_ovf       (ovf[g])
    );
  end

  // Request vector widened to the search function's fixed width.
  always_comb begin
    w_req              = '0;
    w_req[NUM_CH-1:0]  = w_pend_rise | w_pend_fall;
  end

  assign w_sel = CH_W'(rr_find(w_req, int'(r_rr_ptr), NUM_CH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: grant from IDLE when anything is pending, release OFFER on handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_grant     = '0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_load         = 1'b1;
          w_grant[w_sel] = 1'b1;
          w_state_nxt    = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Offer registers load on grant; the pointer moves past the channel once it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_ch   <= '0;
      r_evt_rise <= 1'b0;
      r_evt_fall <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_evt_ch   <= w_sel;
        r_evt_rise <= w_pend_rise[w_sel];
        r_evt_fall <= w_pend_fall[w_sel];
      end
      if (w_accept) begin
        r_rr_ptr <= (r_evt_ch == CH_W'(NUM_CH - 1)) ? '0 : r_evt_ch + CH_W'(1);
      end
    end
  end

  assign evt_valid = (r_state == OFFER);
  assign evt_ch    = r_evt_ch;
  assign evt_rise  = r_evt_rise;
  assign evt_fall  = r_evt_fall;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of pending flags, overflow and round-robin order.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] in_sig;
  logic [N-1:0] rise_en;
  logic [N-1:0] fall_en;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic         evt_rise;
  logic         evt_fall;
  logic [N-1:0] ovf;
  logic [N-1:0] ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // Model state
  bit [N-1:0] m_pr, m_pf, m_ovf, m_prev;
  int         m_ptr, m_ch;
  bit         m_off, m_r, m_f;

  edge_event_arbiter #(.NUM_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sig    (in_sig),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .evt_fall  (evt_fall),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pr = '0; m_pf = '0; m_ovf = '0; m_prev = '0;
    m_ptr = 0; m_ch = 0; m_off = 0; m_r = 0; m_f = 0;
  endtask

  // One clock of the event collector, from the behavioural rules.
  task automatic model_step();
    bit [N-1:0] dr, df, clr;
    int s;
    if (rst) begin
      model_reset();
      return;
    end
    dr  = in_sig & ~m_prev & rise_en;
    df  = ~in_sig & m_prev & fall_en;
    clr = '0;
    if (!m_off) begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        if (s < 0 && (m_pr[(m_ptr + k) % N] || m_pf[(m_ptr + k) % N])) s = (m_ptr + k) % N;
      end
      if (s >= 0) begin
        m_off  = 1;
        m_ch   = s;
        m_r    = m_pr[s];
        m_f    = m_pf[s];
        clr[s] = 1;
      end
    end else if (evt_ready) begin
      m_ptr = (m_ch + 1) % N;
      m_off = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!clr[i] && ((dr[i] && m_pr[i]) || (df[i] && m_pf[i]))) m_ovf[i] = 1;
      else if (ovf_clr[i]) m_ovf[i] = 0;
      m_pr[i] = dr[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pr[i]);
      m_pf[i] = df[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pf[i]);
    end
    m_prev = in_sig;
  endtask

  // Advance one clock; returns just after the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input bit v, input int ch, input bit r, input bit f);
    chk({nm, "_valid"}, int'(evt_valid), int'(v));
    if (v) begin
      chk({nm, "_ch"},   int'(evt_ch),   ch);
      chk({nm, "_rise"}, int'(evt_rise), int'(r));
      chk({nm, "_fall"}, int'(evt_fall), int'(f));
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("m_valid", int'(evt_valid), int'(m_off));
      if (m_off) begin
        chk("m_ch",   int'(evt_ch),   m_ch);
        chk("m_rise", int'(evt_rise), int'(m_r));
        chk("m_fall", int'(evt_fall), int'(m_f));
      end
      chk("m_ovf", int'(ovf), int'(m_ovf));
    end
  end

  initial begin
    rst = 1'b1; in_sig = '0; rise_en = '0; fall_en = '0; evt_ready = 1'b0; ovf_clr = '0;
    model_reset();
    #3;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch",    int'(evt_ch),    0);
    chk("rst_rise",  int'(evt_rise),  0);
    chk("rst_fall",  int'(evt_fall),  0);
    chk("rst_ovf",   int'(ovf),       0);
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single rise on ch2
    rise_en = 4'b0100; evt_ready = 1'b1;
    repeat (4) tick();
    in_sig[2] = 1'b1; tick(); lit("t1_pend", 0, 0, 0, 0);
    in_sig[2] = 1'b0; tick(); lit("t1_offer", 1, 2, 1, 0);
    tick(); lit("t1_done", 0, 0, 0, 0);

    // Single ch3 event wraps the pointer to 0, then two ch0+ch3 pairs
    rise_en = 4'b1001;
    in_sig[3] = 1'b1; tick(); tick(); lit("t2_pre", 1, 3, 1, 0);
    in_sig[3] = 1'b0; tick(); tick();
    for (int p = 0; p < 2; p++) begin
      in_sig = 4'b1001; tick(); lit("t2_pend", 0, 0, 0, 0);
      tick(); lit("t2_a", 1, 0, 1, 0);
      tick(); lit("t2_gap", 0, 0, 0, 0);
      tick(); lit("t2_b", 1, 3, 1, 0);
      tick(); lit("t2_end", 0, 0, 0, 0);
      in_sig = 4'b0000; tick();
    end

    // Stall with ch1 offered, extra rises merge into overflow
    rise_en = 4'b0010; evt_ready = 1'b0;
    in_sig[1] = 1'b1; tick(); lit("t3_pend", 0, 0, 0, 0);
    tick(); lit("t3_offer", 1, 1, 1, 0);
    for (int c = 0; c < 10; c++) begin
      in_sig[1] = (c % 2 == 1);
      tick(); lit("t3_hold", 1, 1, 1, 0);
    end
    chk("t3_ovf_set", int'(ovf[1]), 1);
    in_sig[1] = 1'b0; evt_ready = 1'b1;
    tick(); lit("t3_acc", 0, 0, 0, 0);
    tick(); lit("t3_again", 1, 1, 1, 0);
    tick(); lit("t3_acc2", 0, 0, 0, 0);
    tick(); lit("t3_quiet", 0, 0, 0, 0);
    ovf_clr[1] = 1'b1; tick(); ovf_clr = '0;
    chk("t3_ovf_clr", int'(ovf[1]), 0);

    // Rise-only pulse, then rise and fall as separate events, then merged
    rise_en = 4'b0001; fall_en = 4'b0000;
    in_sig[0] = 1'b1; tick();
    in_sig[0] = 1'b0; tick(); lit("t4_r", 1, 0, 1, 0);
    tick(); tick(); lit("t4_nofall", 0, 0, 0, 0);
    fall_en = 4'b0001;
    in_sig[0] = 1'b1; tick();
    in_sig[0] = 1'b0; tick(); lit("t4_r2", 1, 0, 1, 0);
    tick(); lit("t4_gap", 0, 0, 0, 0);
    tick(); lit("t4_f2", 1, 0, 0, 1);
    tick();
    rise_en = 4'b0011;
    in_sig[1] = 1'b1; tick(); evt_ready = 1'b0;
    tick(); lit("t4_blk", 1, 1, 1, 0);
    in_sig[0] = 1'b1; tick();
    in_sig[0] = 1'b0; tick();
    evt_ready = 1'b1; tick(); lit("t4_acc", 0, 0, 0, 0);
    tick(); lit("t4_both", 1, 0, 1, 1);
    tick();
    fall_en = 4'b0000; in_sig = '0; tick(); tick();

    // Reset during an offer
    rise_en = 4'b0100; evt_ready = 1'b0;
    in_sig[2] = 1'b1; tick(); tick(); lit("t5_offer", 1, 2, 1, 0);
    rst = 1'b1; #1;
    chk("t5_async_valid", int'(evt_valid), 0);
    chk("t5_async_ch",    int'(evt_ch),    0);
    chk("t5_async_rise",  int'(evt_rise),  0);
    model_reset();
    in_sig[2] = 1'b0; tick(); tick();
    rst = 1'b0; evt_ready = 1'b1;
    tick(); tick(); tick(); lit("t5_nostale", 0, 0, 0, 0);
    in_sig[2] = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; tick(); lit("t5_hi_pend", 0, 0, 0, 0);
    tick(); lit("t5_hi_evt", 1, 2, 1, 0);
    tick();

    // ch3 granted in the same cycle a new ch3 rise arrives
    in_sig = '0; rise_en = 4'b1100; evt_ready = 1'b0; tick();
    in_sig[2] = 1'b1; tick();
    tick(); lit("t6_ch2", 1, 2, 1, 0);
    in_sig[3] = 1'b1; tick();
    in_sig[3] = 1'b0; tick();
    evt_ready = 1'b1; tick(); lit("t6_acc", 0, 0, 0, 0);
    in_sig[3] = 1'b1; tick(); lit("t6_g1", 1, 3, 1, 0);
    tick(); lit("t6_gap", 0, 0, 0, 0);
    tick(); lit("t6_g2", 1, 3, 1, 0);
    tick(); lit("t6_end", 0, 0, 0, 0);
    chk("t6_no_ovf", int'(ovf[3]), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        rise_en = 4'($urandom);
        fall_en = 4'($urandom);
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) in_sig[i] = ~in_sig[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Multi-channel edge-event collector and scheduler. It detects rising and/or falling edges on NUM_CH synchronous input signals, holds one pending flag per edge type per channel, and serialises the pending events onto a single valid/ready event port using round-robin arbitration. It sits between the per-signal edge detection and the consumer, typically an interrupt or status logger, that can accept one event per handshake.

Parameters:
NUM_CH, 4, number of input channels (2..16)
CH_W, $clog2(NUM_CH), width of channel index (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
in_sig  input  NUM_CH  monitored signals, already synchronous to clk
rise_en  input  NUM_CH  per-channel rising-edge enable
fall_en  input  NUM_CH  per-channel falling-edge enable
evt_valid  output  1  event offered
evt_ready  input  1  consumer accepts event
evt_ch  output  CH_W  channel index of offered event
evt_rise  output  1  offered event includes a rising edge
evt_fall  output  1  offered event includes a falling edge
ovf  output  NUM_CH  sticky per-channel overflow flags
ovf_clr  input  NUM_CH  per-channel overflow clear, one-cycle pulse

Behaviour:
- Reset (async, rst=1): in_sig_d, pend_rise, pend_fall, ovf, rr_ptr, evt_ch, evt_rise and evt_fall all 0; evt_valid=0; state=IDLE. Takes effect immediately, including mid-offer. Any offered event is discarded.
- Edge detect per channel: in_sig_d <= in_sig every cycle. rise_det = in_sig & ~in_sig_d & rise_en. fall_det = ~in_sig & in_sig_d & fall_en.
- Because in_sig_d resets to 0, a channel held high through reset produces a rise event on the first cycle after reset when rise_en=1.
- Pending: pend_rise[i] sets on the clock edge where rise_det[i]=1; pend_fall[i] behaves the same for falls. Enables gate detection only. Clearing an enable does not drop an already-pending flag.
- Overflow: if a detect occurs while the same-type pending flag is already 1 and not being cleared by a grant that cycle, ovf[i] <= 1 and the event is merged. ovf[i] clears on ovf_clr[i]. If set and clear coincide, set wins.
- FSM, two states:
  - IDLE: evt_valid=0. If any pend_rise|pend_fall, select the first channel with a pending flag at or after rr_ptr, searching upward with wrap modulo NUM_CH. Register evt_ch=sel, evt_rise=pend_rise[sel], evt_fall=pend_fall[sel]. Clear both pending flags of sel, go to OFFER.
  - OFFER: evt_valid=1. evt_ch, evt_rise and evt_fall are held stable until handshake. When evt_valid&evt_ready: rr_ptr <= (evt_ch==NUM_CH-1) ? 0 : evt_ch+1, then go to IDLE.
  - No other states.
- Latency: edge sampled at posedge k sets the pending flag at k. Grant at k+1 gives evt_valid high after k+1. The minimum spacing between accepted events is 2 cycles, because of the IDLE bubble.
- Simultaneous grant-clear and new detect on the same channel and type: the new detect sets the flag, so set wins. No overflow is flagged, and the edge is reported as a separate later event.
- Rise and fall both pending on one channel at grant: both are reported in a single event (evt_rise=evt_fall=1).
- evt_ready while evt_valid=0 is ignored.

Decomposition:
- Shared package edge_evt_pkg holds:
  - state typedef (IDLE, OFFER);
  - a function clog2_min1 for CH_W, forced to ≥1;
  - a round-robin find-first function (req vector, ptr) returning index.
- Sub-module edge_evt_chan, one per channel, holds in_sig_d, pending flags, overflow, enables and the clear/set priority.
- The top level holds the FSM, arbiter and output registers.

Test Plan:
- Reset release with in_sig=4'b0000 and rise_en=4'b0100; pulse in_sig[2] high at cycle 5 and keep ready=1 → one event with evt_ch=2, evt_rise=1, evt_fall=0, and evt_valid rises 1 cycle after the pending flag sets.
- Rising edges on ch0 and ch3 in the same cycle, rr_ptr=0, ready=1 → events in order ch0 then ch3, with one idle cycle between. A subsequent ch0+ch3 pair comes out as ch0 then ch3 again, because rr_ptr wrapped to 0 after ch3.
- Hold evt_ready=0 for 10 cycles with ch1 offered → evt_valid, evt_ch=1 and the flags stay constant. Toggle in_sig[1] rise twice meanwhile → ovf[1]=1 and exactly one additional ch1 event follows. ovf_clr[1] pulse → ovf[1]=0.
- fall_en=0, rise_en=1 on ch0; apply a 1-cycle high pulse → only evt_rise=1. With both enables set → two events, rise then fall, or one event with both flags if the fall occurs before the grant.
- Assert rst during OFFER → evt_valid drops to 0 asynchronously with no handshake completion. After release, no stale event appears unless in_sig is high with rise_en=1.
- Channel 3 is granted while a new rise arrives on ch3 in the same cycle → no ovf, and a second ch3 event follows.
